tw_ram_writer: RTL

//   Generates one NTT stage's twiddle table on the fly and writes it into that stage's twiddle RAM.
//   It is the write-side counterpart of the per-stage twiddle ROM read path.
//   On start it writes root^k mod q for k = 0 .. 2^STAGE-1, one entry per address.
//   It uses the inverse root when intt is set, so tables can be reloaded at runtime for a new q or direction.

---
 rtl/tw_ram_writer_pkg.sv | 16 +
 rtl/tw_ram_writer_if.sv | 28 ++
 rtl/tw_ram_writer_modmul.sv | 55 +++++
 rtl/tw_ram_writer.sv | 96 +++++++++
 4 files changed

// File: rtl/tw_ram_writer_pkg.sv
// Shared types and helpers for the twiddle-table writer.
package tw_ram_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } tw_state_e;

  // Modmul latency: multiplier + reduction stages, never below one register.
  function automatic int tw_lat(input int dm, input int dr);
    return (dm + dr < 1) ? 1 : dm + dr;
  endfunction

endpackage

// File: rtl/tw_ram_writer_if.sv
// Control and RAM-write bundle of the twiddle-table writer.
interface tw_ram_writer_if #(
  parameter int LOGQ = 5,
  parameter int LOGN = 3
);
  logic            start;
  logic            intt;
  logic [LOGQ-1:0] q;
  logic [LOGQ-1:0] w;
  logic [LOGQ-1:0] w_inv;
  logic            we;
  logic [LOGN-1:0] waddr;
  logic [LOGQ-1:0] din;
  logic            busy;
  logic            done;

  // Controller side: kicks off a table load and watches the RAM writes.
  modport master (
    output start, intt, q, w, w_inv,
    input  we, waddr, din, busy, done
  );

  // Writer side.
  modport slave (
    input  start, intt, q, w, w_inv,
    output we, waddr, din, busy, done
  );
endinterface

// File: rtl/tw_ram_writer_modmul.sv
// Fully pipelined a*b mod q with a fixed latency and no handshake.
// The product travels unreduced until the reduction stage, then reduced.
module tw_modmul
  import tw_ram_writer_pkg::*;
#(
  parameter int LOGQ      = 5,
  parameter int DELAY_MUL = 0,
  parameter int DELAY_RED = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vld_i,
  input  logic [LOGQ-1:0] a_i,
  input  logic [LOGQ-1:0] b_i,
  input  logic [LOGQ-1:0] q_i,
  output logic            vld_o,
  output logic [LOGQ-1:0] res_o
);
  localparam int LAT  = tw_lat(DELAY_MUL, DELAY_RED);
  // 1-based pipeline stage whose register captures the reduced value.
  localparam int RIDX = (DELAY_MUL + 1 > LAT) ? LAT : DELAY_MUL + 1;
  localparam int PW   = 2 * LOGQ;

  logic [LAT-1:0] vld_pipe;
  logic [PW-1:0]  p_pipe [LAT];
  logic [LOGQ-1:0] m_pipe [LAT];
  logic [PW-1:0]  p0;
  logic [LOGQ-1:0] unused_hi;

  function automatic logic [PW-1:0] red(input logic [PW-1:0] x, input logic [LOGQ-1:0] m);
    return x % {{LOGQ{1'b0}}, m};
  endfunction

  assign p0 = PW'(a_i) * PW'(b_i);

  // Data/modulus shift pipeline; reduction applied when entering stage RIDX.
  always_ff @(posedge clk) begin
    p_pipe[0] <= (RIDX == 1) ? red(p0, q_i) : p0;
    m_pipe[0] <= q_i;
    for (int i = 1; i < LAT; i++) begin
      p_pipe[i] <= (i + 1 == RIDX) ? red(p_pipe[i-1], m_pipe[i-1]) : p_pipe[i-1];
      m_pipe[i] <= m_pipe[i-1];
    end
  end

  // Valid shift register; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= LAT'({vld_pipe, vld_i});
  end

  assign vld_o     = vld_pipe[LAT-1];
  assign res_o     = p_pipe[LAT-1][LOGQ-1:0];
  assign unused_hi = p_pipe[LAT-1][PW-1:LOGQ];
endmodule

// File: rtl/tw_ram_writer.sv
// Generates root^k mod q, k = 0..2^STAGE-1, and writes it to a stage twiddle RAM.
module tw_ram_writer
  import tw_ram_writer_pkg::*;
#(
  parameter int LOGQ      = 5,
  parameter int LOGN      = 3,
  parameter int DELAY_MUL = 0,
  parameter int DELAY_RED = 0,
  parameter int STAGE     = 2
) (
  input  logic            clk,
  input  logic            reset,
  tw_ram_writer_if.slave  bus
);
  localparam int              NUM  = 1 << STAGE;
  localparam logic [LOGN-1:0] LAST = LOGN'(NUM - 1);

  tw_state_e       state_q;
  logic [LOGQ-1:0] q_q, root_q, acc_q, din_q;
  logic [LOGN-1:0] addr_q;
  logic            we_q, busy_q, done_q;
  logic            mm_vld, mm_rdy;
  logic [LOGQ-1:0] mm_res;

  // Next power is requested only from a write that is not the last one.
  assign mm_vld = (state_q == S_WR) && (addr_q != LAST);

  tw_modmul #(
    .LOGQ(LOGQ), .DELAY_MUL(DELAY_MUL), .DELAY_RED(DELAY_RED)
  ) u_modmul (
    .clk(clk), .reset(reset), .vld_i(mm_vld),
    .a_i(acc_q), .b_i(root_q), .q_i(q_q),
    .vld_o(mm_rdy), .res_o(mm_res)
  );

  // Control FSM with registered RAM-write and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      root_q  <= '0;
      acc_q   <= LOGQ'(1);
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            q_q     <= bus.q;
            root_q  <= bus.intt ? bus.w_inv : bus.w;
            acc_q   <= LOGQ'(1);
            addr_q  <= '0;
            din_q   <= LOGQ'(1);
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_WR;
          end
        end
        S_WR: begin
          we_q <= 1'b0;
          if (addr_q == LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The modmul valid marks the last wait cycle (fixed latency).
          if (mm_rdy) begin
            acc_q   <= mm_res;
            din_q   <= mm_res;
            addr_q  <= addr_q + LOGN'(1);
            we_q    <= 1'b1;
            state_q <= S_WR;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.we    = we_q;
  assign bus.waddr = addr_q;
  assign bus.din   = din_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
